uart_rx: RTL
============

# uart_rx

Serial receive front end for the host link. Oversamples the `rx_serial` pin, frames 8N1 characters, and presents each good byte as a single-cycle pulse to `uart_processor` (`in_uart_byte` / `in_uart_byte_ready`). It reports framing errors and line breaks. It honours the processor's `out_uart_rx_reset` as a synchronous soft reset.

## Interface
- `CLOCKS_PER_BIT`, 40, clock cycles per bit period; minimum 8. H = `CLOCKS_PER_BIT/2` (integer division).
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rx_reset`  in  1  synchronous soft reset, driven by `out_uart_rx_reset`.
- `rx_serial`  in  1  asynchronous serial line; idles high.
- `out_byte`  out  8  last good byte received. Reset value 0.
- `out_byte_ready`  out  1  one-cycle pulse when `out_byte` is updated. Reset value 0.
- `out_framing_error`  out  1  one-cycle pulse on a bad stop bit with nonzero data. Reset value 0.
- `out_break`  out  1  level signal, high during a break. Reset value 0.
- `out_idle`  out  1  high only in the IDLE state. Reset value 0.

## Operation
- **Synchronizer:** `rx_serial` passes through two flops, both reset to 1. All logic uses the synchronized line `rxs`.
- **States:** RECOVER, IDLE, START, DATA, STOP. Reset state is RECOVER.
- **Bit counter:** `bit_cnt` runs from 0 to `CLOCKS_PER_BIT-1`. `bit_idx` runs from 0 to 7.
- **Majority vote:** three samples of `rxs` are taken at `bit_cnt` = H-1, H and H+1. The bit decision is the majority of the three, made in the H+1 cycle.
- **RECOVER:** wait until `rxs` has been high for `CLOCKS_PER_BIT` consecutive cycles, then go to IDLE. Any low sample restarts the count.
- **IDLE:** when `rxs` = 0, go to START with `bit_cnt` = 0.
- **START:**
  - If the decision is 1, it is a false start: go to IDLE with no output.
  - Otherwise, at `bit_cnt` = `CLOCKS_PER_BIT-1`, go to DATA with `bit_idx` = 0.
- **DATA:**
  - Each decision is shifted into an 8-bit shift register, LSB first.
  - After the final cycle of bit 7, go to STOP.
- **STOP, at decision time:**
  - Decision 1: load `out_byte` from the shift register, pulse `out_byte_ready` the next cycle, and go to IDLE. The remainder of the stop bit is not waited out.
  - Decision 0 and shift register 0: assert `out_break` and go to RECOVER. `out_break` deasserts on the first cycle `rxs` = 1.
  - Decision 0 and shift register nonzero: pulse `out_framing_error` and go to RECOVER.
- **`rx_reset`:**
  - Priority is below `reset_n` and above everything else.
  - Clears `out_byte_ready`, `out_framing_error`, `out_break`, the shift register and the counters, then forces RECOVER.
  - `out_byte` is retained.
  - While `rx_reset` is held, the block stays in RECOVER with the high-time count held at 0.
- **Back-to-back frames:** a start edge arriving directly after a stop bit, with no idle gap, is accepted.

## Timing
- **Start detection:** 3 clocks after the pin falling edge, the block is in START with `bit_cnt` = 0 (2 synchronizer clocks plus 1 IDLE detect clock). That cycle is start-relative cycle 0.
- **Frame layout:** frame bit k (0 = start, 1–8 = data, 9 = stop) occupies start-relative cycles k·CPB through k·CPB+CPB-1.
- **`out_byte_ready`:** high in start-relative cycle 9·CPB+H+2.
  - For CPB = 40 this is cycle 382, i.e. 385 clocks after the pin edge.
  - `out_byte` is valid in the same cycle and stable until the next pulse.
- **`out_framing_error`:** asserts in the same relative cycle as `out_byte_ready` would.
- **Pulse exclusivity:** `out_byte_ready` and `out_framing_error` are never high together.
- **`out_idle`** is combinational from the state register.
- **Glitch rejection:** any low pulse on `rxs` shorter than H-1 cycles is rejected.
- **Counter widths:** counters are sized as `$clog2(CLOCKS_PER_BIT)` bits and never wrap past `CLOCKS_PER_BIT-1`.
- **Simultaneous events:** `rx_reset` in the same cycle as a STOP decision suppresses that decision's pulse.

## Structure
- **Package `uart_pkg`:** the state enum, `UART_DEFAULT_CLOCKS_PER_BIT` = 40, and the frame constants `UART_DATA_BITS` = 8 and `UART_STOP_IDX` = 9. The package is shared with the future `uart_tx`.
- **Sub-module `sync_ff2`:** a 2-flop synchronizer with a reset-value parameter. It is instantiated with the reset value 1.
- **Remaining logic:** the FSM, counters, vote and shift register live in one always block plus the output registers.

## Test plan
1. **Good byte:** after reset, hold the line high 40 cycles, then send 0xA5 at CPB = 40. Expect `out_byte` = 0xA5, a one-cycle `out_byte_ready` at 385 clocks after the pin edge, and no error or break.
2. **False start:** drive a 10-cycle low glitch from IDLE. Expect no pulses, the block back in IDLE, and `out_idle` = 1 at start-relative cycle H+2.
3. **Framing error:** send 0x3C with the stop bit low, then raise the line. Expect an `out_framing_error` pulse and no ready. `out_idle` returns 40 cycles after the line goes high.
4. **Break:** hold the line low for 12 bit periods. Expect `out_break` = 1 from the stop decision until `rxs` rises, no ready, then a following 0x81 received correctly.
5. **Soft reset mid-frame:** assert `rx_reset` for 1 cycle during data bit 4. Expect no ready pulse and `out_byte` unchanged. A subsequent 0x5A, sent after 40+ high cycles, is received.
6. **Noise and back-to-back:** invert the H sample of bit 3 in 0xFF, then send 0x00 immediately after the stop bit. Expect 0xFF then 0x00, two ready pulses, and no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding,
// default bit timing and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam int UART_DEFAULT_CLOCKS_PER_BIT = 40;
    localparam int UART_DATA_BITS              = 8;
    localparam int UART_STOP_IDX               = 9;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous input,
// with a selectable reset value.
module sync_ff2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, majority-voted bits,
// byte/framing-error pulses and a break level output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = UART_DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_reset,
    input  logic       rx_serial,
    output logic [7:0] out_byte,
    output logic       out_byte_ready,
    output logic       out_framing_error,
    output logic       out_break,
    output logic       out_idle
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int H  = CLOCKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic rxs;

    sync_ff2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (rx_serial),
        .q_o   (rxs)
    );

    uart_state_e   state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          samp0_q;
    logic          samp1_q;
    logic [7:0]    byte_q;
    logic          ready_q;
    logic          ferr_q;
    logic          brk_q;

    logic dec_d;
    logic at_dec;
    logic at_last;

    assign dec_d   = maj3(samp0_q, samp1_q, rxs);
    assign at_dec  = (bit_cnt_q == CNT_DEC);
    assign at_last = (bit_cnt_q == CNT_LAST);

    // Framing FSM with bit timing, vote, shift register and outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RECOVER;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            samp0_q   <= 1'b1;
            samp1_q   <= 1'b1;
            byte_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else if (rx_reset) begin
            state_q   <= ST_RECOVER;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (bit_cnt_q == CNT_S0) samp0_q <= rxs;
            if (bit_cnt_q == CNT_S1) samp1_q <= rxs;
            unique case (state_q)
                ST_RECOVER: begin
                    if (rxs) brk_q <= 1'b0;
                    if (!rxs) begin
                        bit_cnt_q <= '0;
                    end else if (at_last) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    bit_cnt_q <= '0;
                    if (!rxs) state_q <= ST_START;
                end
                ST_START: begin
                    if (at_dec && dec_d) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (at_last) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (at_dec) shreg_q <= {dec_d, shreg_q[7:1]};
                    if (at_last) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (at_dec) begin
                        bit_cnt_q <= '0;
                        if (dec_d) begin
                            byte_q  <= shreg_q;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (shreg_q == '0) begin
                            brk_q   <= 1'b1;
                            state_q <= ST_RECOVER;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_RECOVER;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: begin
                    bit_cnt_q <= '0;
                    state_q   <= ST_RECOVER;
                end
            endcase
        end
    end

    assign out_byte          = byte_q;
    assign out_byte_ready    = ready_q;
    assign out_framing_error = ferr_q;
    assign out_break         = brk_q;
    assign out_idle          = (state_q == ST_IDLE);

endmodule
